// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential integer divider:
//   - FSM state encoding (IDLE, ITER, FIX, DONE)
//   - cond_neg(): conditional two's-complement negation, usable for any
//     operand width up to MAX_W. Callers zero-extend a WIDTH-bit value to
//     MAX_W bits and keep the low WIDTH bits of the result. Those low bits
//     are the WIDTH-bit negation, so the helper serves as both |x| and -x.
// -----------------------------------------------------------------------------
package div_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] value,
                                                  input logic             negate);
        logic [MAX_W-1:0] result;
        if (negate) begin
            result = ~value + {{(MAX_W-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/int_divider_seq_if.sv
// -----------------------------------------------------------------------------
// int_divider_seq_if
// go/done handshake and operand/result bundle of the sequential divider.
//   master : drives go, signed_mode, dividend, divisor; observes results
//   slave  : the divider itself
// Signals:
//   go          start request (sampled only when the divider can accept)
//   signed_mode 1 = two's-complement operands, sampled with go
//   dividend    numerator, sampled with go
//   divisor     denominator, sampled with go
//   quotient    registered result
//   remainder   registered result
//   busy        high from the accepting edge until done falls
//   done        one-cycle pulse, results valid from this cycle
//   error       divide-by-zero flag, valid with done
// -----------------------------------------------------------------------------
interface int_divider_seq_if #(
    parameter int WIDTH = 8
);
    logic             go;
    logic             signed_mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        output go, signed_mode, dividend, divisor,
        input  quotient, remainder, busy, done, error
    );

    modport slave (
        input  go, signed_mode, dividend, divisor,
        output quotient, remainder, busy, done, error
    );
endinterface

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring shift-subtract stage.
//   r_in  : partial remainder R (WIDTH+1 bits)
//   x_msb : next dividend bit shifted into R
//   y     : divisor magnitude
//   r_out : next partial remainder
//   q_bit : quotient bit produced by this stage
// Kept separate so that several stages can be chained for a higher radix.
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   r_in,
    input  logic             x_msb,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH:0]   r_out,
    output logic             q_bit
);

    logic [WIDTH:0] t_s;
    logic [WIDTH:0] y_ext_s;
    logic           ge_s;
    logic           r_msb_unused_s;

    // R never exceeds Y-1 between stages, so its top bit carries no information
    // into the shifted trial value.
    assign r_msb_unused_s = r_in[WIDTH];

    // Trial subtract: shift the next dividend bit in and compare against Y.
    always_comb begin
        t_s     = {r_in[WIDTH-1:0], x_msb};
        y_ext_s = {1'b0, y};
        ge_s    = (t_s >= y_ext_s);
        if (ge_s) begin
            r_out = t_s - y_ext_s;
        end else begin
            r_out = t_s;
        end
        q_bit = ge_s;
    end

endmodule

// File: rtl/int_divider_seq.sv
// -----------------------------------------------------------------------------
// int_divider_seq
// Sequential WIDTH-bit integer divider, restoring algorithm, one quotient bit
// per clock. Unsigned or two's-complement signed operands; divide-by-zero is
// reported through error with quotient = all ones and remainder = dividend.
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset; aborts any operation in flight
//   bus   int_divider_seq_if.slave (go/done handshake, operands, results)
// Latency: WIDTH+1 cycles from the accepting edge to done, 1 cycle for a zero
// divisor. A new go is accepted in IDLE and on the DONE cycle (back-to-back).
// -----------------------------------------------------------------------------
module int_divider_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    int_divider_seq_if.slave     bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH:0]   r_r;
    logic             q_neg_r;
    logic             r_neg_r;
    logic             dz_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             busy_r;
    logic             done_r;
    logic             error_r;

    logic             dvd_neg_s;
    logic             dvs_neg_s;
    logic [WIDTH-1:0] dvd_abs_s;
    logic [WIDTH-1:0] dvs_abs_s;
    logic             dvs_zero_s;
    logic             accept_s;
    logic [WIDTH-1:0] q_fix_s;
    logic [WIDTH-1:0] r_fix_s;
    logic [WIDTH:0]   r_next_s;
    logic             q_bit_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in  (r_r),
        .x_msb (x_r[WIDTH-1]),
        .y     (y_r),
        .r_out (r_next_s),
        .q_bit (q_bit_s)
    );

    // Operand magnitudes, start condition and sign-corrected final results.
    // The magnitude of the most-negative operand fits in WIDTH unsigned bits.
    always_comb begin
        dvd_neg_s  = bus.signed_mode & bus.dividend[WIDTH-1];
        dvs_neg_s  = bus.signed_mode & bus.divisor[WIDTH-1];
        dvd_abs_s  = WIDTH'(cond_neg(MAX_W'(bus.dividend), dvd_neg_s));
        dvs_abs_s  = WIDTH'(cond_neg(MAX_W'(bus.divisor), dvs_neg_s));
        dvs_zero_s = (bus.divisor == {WIDTH{1'b0}});
        accept_s   = bus.go & ((state_r == IDLE) | (state_r == DONE));
        q_fix_s    = WIDTH'(cond_neg(MAX_W'(x_r), q_neg_r));
        r_fix_s    = WIDTH'(cond_neg(MAX_W'(r_r[WIDTH-1:0]), r_neg_r));
    end

    // FSM, iteration counter, shift registers and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            x_r         <= {WIDTH{1'b0}};
            y_r         <= {WIDTH{1'b0}};
            r_r         <= {(WIDTH+1){1'b0}};
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            dz_r        <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                busy_r <= 1'b1;
                r_r    <= {(WIDTH+1){1'b0}};
                cnt_r  <= CNT_W'(WIDTH);
                if (dvs_zero_s) begin
                    // Zero divisor skips ITER but still passes through FIX so
                    // that done lands exactly one edge after go.
                    dz_r    <= 1'b1;
                    x_r     <= bus.dividend;
                    y_r     <= bus.divisor;
                    q_neg_r <= 1'b0;
                    r_neg_r <= 1'b0;
                    state_r <= FIX;
                end else begin
                    dz_r    <= 1'b0;
                    x_r     <= dvd_abs_s;
                    y_r     <= dvs_abs_s;
                    q_neg_r <= dvd_neg_s ^ dvs_neg_s;
                    r_neg_r <= dvd_neg_s;
                    state_r <= ITER;
                end
            end else begin
                case (state_r)
                    ITER: begin
                        r_r   <= r_next_s;
                        x_r   <= {x_r[WIDTH-2:0], q_bit_s};
                        cnt_r <= cnt_r - CNT_W'(1);
                        if (cnt_r == CNT_W'(1)) begin
                            state_r <= FIX;
                        end else begin
                            state_r <= ITER;
                        end
                    end
                    FIX: begin
                        if (dz_r) begin
                            quotient_r  <= {WIDTH{1'b1}};
                            remainder_r <= x_r;
                            error_r     <= 1'b1;
                        end else begin
                            quotient_r  <= q_fix_s;
                            remainder_r <= r_fix_s;
                            error_r     <= 1'b0;
                        end
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end
                    DONE: begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    default: begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.error     = error_r;

endmodule

// File: tb/tb_int_divider_seq.sv
// -----------------------------------------------------------------------------
// tb_int_divider_seq
// Self-checking bench for int_divider_seq at WIDTH = 8, 16 and 2.
// Expected results come from plain integer division (truncating toward zero,
// remainder taking the dividend's sign), masked to WIDTH bits.
// -----------------------------------------------------------------------------
module tb_int_divider_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    int_divider_seq_if #(.WIDTH(8))  bus8 ();
    int_divider_seq_if #(.WIDTH(16)) bus16 ();
    int_divider_seq_if #(.WIDTH(2))  bus2 ();

    int_divider_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    int_divider_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    int_divider_seq #(.WIDTH(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       e;
        int         lat;
        int         acc;
    } exp_t;

    exp_t exp_q[$];
    bit   prev_done = 1'b0;

    logic [31:0] tq;
    logic [31:0] tr;
    logic        te;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference division on WIDTH=w operands.
    task automatic model(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int w,
                         output logic [31:0] q, output logic [31:0] r, output logic e);
        longint m, sa, sb;
        m  = (longint'(1) << w) - 1;
        sa = longint'(a) & m;
        sb = longint'(b) & m;
        if (sb == 0) begin
            q = 32'(m);
            r = 32'(sa);
            e = 1'b1;
        end else begin
            if (sgn) begin
                if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
                if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
            end
            q = 32'((sa / sb) & m);
            r = 32'((sa % sb) & m);
            e = 1'b0;
        end
    endtask

    // Start an 8-bit operation at a negedge and record what it must produce.
    task automatic issue8(input bit sgn, input logic [7:0] a, input logic [7:0] b);
        exp_t        e;
        logic [31:0] q, r;
        logic        err;
        model(sgn, {24'd0, a}, {24'd0, b}, 8, q, r, err);
        e.q   = q[7:0];
        e.r   = r[7:0];
        e.e   = err;
        e.lat = (b == 8'd0) ? 1 : 9;
        e.acc = cyc;
        exp_q.push_back(e);
        bus8.signed_mode = sgn;
        bus8.dividend    = a;
        bus8.divisor     = b;
        bus8.go          = 1'b1;
        @(negedge clk);
        bus8.go          = 1'b0;
        bus8.dividend    = 8'($urandom);
        bus8.divisor     = 8'($urandom);
        bus8.signed_mode = 1'($urandom);
    endtask

    task automatic wait_done8();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus8.done;
        end
        check("w8_done_timeout", seen, 1);
    endtask

    task automatic run8(input bit sgn, input logic [7:0] a, input logic [7:0] b);
        repeat (2) @(negedge clk);
        issue8(sgn, a, b);
        wait_done8();
    endtask

    // One operation on the 16- or 2-bit instance, fully checked here.
    task automatic op_wide(input int w, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q_o, output logic [31:0] r_o);
        logic [31:0] eq, er;
        logic        ee, e_o, dz;
        int          acc, waited;
        bit          seen;
        model(sgn, a, b, w, eq, er, ee);
        if (w == 16) begin
            dz = (b[15:0] == 16'd0);
            bus16.signed_mode = sgn;
            bus16.dividend    = a[15:0];
            bus16.divisor     = b[15:0];
            bus16.go          = 1'b1;
        end else begin
            dz = (b[1:0] == 2'd0);
            bus2.signed_mode = sgn;
            bus2.dividend    = a[1:0];
            bus2.divisor     = b[1:0];
            bus2.go          = 1'b1;
        end
        acc = cyc;
        seen = 1'b0;
        waited = 0;
        q_o = 32'd0;
        r_o = 32'd0;
        e_o = 1'b0;
        @(negedge clk);
        bus16.go = 1'b0;
        bus2.go  = 1'b0;
        while (!seen && waited < 40) begin
            @(negedge clk);
            waited++;
            if (w == 16) begin
                seen = bus16.done;
                q_o  = {16'd0, bus16.quotient};
                r_o  = {16'd0, bus16.remainder};
                e_o  = bus16.error;
            end else begin
                seen = bus2.done;
                q_o  = {30'd0, bus2.quotient};
                r_o  = {30'd0, bus2.remainder};
                e_o  = bus2.error;
            end
        end
        check($sformatf("w%0d_done_timeout", w), seen, 1);
        check($sformatf("w%0d_q %0h/%0h s%0d", w, a, b, sgn), q_o, eq);
        check($sformatf("w%0d_r %0h/%0h s%0d", w, a, b, sgn), r_o, er);
        check($sformatf("w%0d_err %0h/%0h", w, a, b), e_o, ee);
        check($sformatf("w%0d_latency", w), cyc - acc - 1, dz ? 1 : w + 1);
    endtask

    // Compare process for the 8-bit instance: results, latency and handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus8.done) begin
                check("done_single_cycle", prev_done, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("w8_quotient", bus8.quotient, e.q);
                    check("w8_remainder", bus8.remainder, e.r);
                    check("w8_error", bus8.error, e.e);
                    check("w8_latency", cyc - e.acc - 1, e.lat);
                    check("busy_with_done", bus8.busy, 1);
                end
            end else if (prev_done) begin
                check("busy_after_done", bus8.busy, exp_q.size() != 0);
            end
            prev_done = bus8.done;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus8.go = 1'b0;  bus8.signed_mode = 1'b0;  bus8.dividend = 8'd0;   bus8.divisor = 8'd0;
        bus16.go = 1'b0; bus16.signed_mode = 1'b0; bus16.dividend = 16'd0; bus16.divisor = 16'd0;
        bus2.go = 1'b0;  bus2.signed_mode = 1'b0;  bus2.dividend = 2'd0;   bus2.divisor = 2'd0;
        repeat (2) @(negedge clk);
        check("rst_quotient", bus8.quotient, 0);
        check("rst_remainder", bus8.remainder, 0);
        check("rst_busy", bus8.busy, 0);
        check("rst_done", bus8.done, 0);
        check("rst_error", bus8.error, 0);

        // Pin the reference model with hand-computed values.
        model(1'b0, 32'd100, 32'd7, 8, tq, tr, te);
        check("model_u100_7_q", tq, 32'h0E);
        check("model_u100_7_r", tr, 32'h02);
        model(1'b1, 32'h9C, 32'h07, 8, tq, tr, te);
        check("model_sm100_7_q", tq, 32'hF2);
        check("model_sm100_7_r", tr, 32'hFE);
        model(1'b1, 32'h80, 32'hFF, 8, tq, tr, te);
        check("model_ovf_q", tq, 32'h80);
        check("model_ovf_e", te, 0);

        rst_n = 1'b1;

        run8(1'b0, 8'd100, 8'd7);
        check("u100_7_q", bus8.quotient, 8'h0E);
        check("u100_7_r", bus8.remainder, 8'h02);
        check("u100_7_e", bus8.error, 0);
        run8(1'b1, 8'h9C, 8'h07);
        check("sm100_7_q", bus8.quotient, 8'hF2);
        check("sm100_7_r", bus8.remainder, 8'hFE);
        run8(1'b1, 8'h64, 8'hF9);
        check("s100_m7_q", bus8.quotient, 8'hF2);
        check("s100_m7_r", bus8.remainder, 8'h02);
        run8(1'b0, 8'h37, 8'h00);
        check("dz_u_q", bus8.quotient, 8'hFF);
        check("dz_u_r", bus8.remainder, 8'h37);
        check("dz_u_e", bus8.error, 1);
        run8(1'b1, 8'h37, 8'h00);
        check("dz_s_q", bus8.quotient, 8'hFF);
        check("dz_s_r", bus8.remainder, 8'h37);
        check("dz_s_e", bus8.error, 1);
        run8(1'b1, 8'h80, 8'hFF);
        check("ovf_q", bus8.quotient, 8'h80);
        check("ovf_r", bus8.remainder, 8'h00);
        check("ovf_e", bus8.error, 0);
        run8(1'b0, 8'hFF, 8'h01);
        check("uff_1_q", bus8.quotient, 8'hFF);
        check("uff_1_r", bus8.remainder, 8'h00);

        // go mid-ITER is ignored; go on the done cycle is accepted.
        repeat (2) @(negedge clk);
        issue8(1'b0, 8'hC8, 8'h05);
        repeat (3) @(negedge clk);
        bus8.signed_mode = 1'b0;
        bus8.dividend    = 8'h11;
        bus8.divisor     = 8'h03;
        bus8.go          = 1'b1;
        @(negedge clk);
        bus8.go = 1'b0;
        wait_done8();
        check("ignore_q", bus8.quotient, 8'h28);
        check("ignore_r", bus8.remainder, 8'h00);
        issue8(1'b0, 8'h11, 8'h03);
        wait_done8();
        check("b2b_q", bus8.quotient, 8'h05);
        check("b2b_r", bus8.remainder, 8'h02);
        repeat (3) @(negedge clk);
        check("hold_q", bus8.quotient, 8'h05);
        check("hold_r", bus8.remainder, 8'h02);

        // Asynchronous reset during the 4th ITER cycle.
        issue8(1'b0, 8'd200, 8'd3);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_quotient", bus8.quotient, 0);
        check("arst_remainder", bus8.remainder, 0);
        check("arst_busy", bus8.busy, 0);
        check("arst_done", bus8.done, 0);
        check("arst_error", bus8.error, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run8(1'b0, 8'd200, 8'd3);
        check("u200_3_q", bus8.quotient, 8'h42);
        check("u200_3_r", bus8.remainder, 8'h02);

        // WIDTH=16: directed then random operands.
        op_wide(16, 1'b0, 32'd200, 32'd3, tq, tr);
        check("w16_200_3_q", tq, 32'h42);
        check("w16_200_3_r", tr, 32'h02);
        op_wide(16, 1'b1, 32'h8000, 32'hFFFF, tq, tr);
        check("w16_ovf_q", tq, 32'h8000);
        for (int i = 0; i < 20; i++) begin
            op_wide(16, 1'($urandom), $urandom, ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom, tq, tr);
        end

        // WIDTH=2: every operand pair in both modes.
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 4; a++) begin
                for (int b = 0; b < 4; b++) begin
                    op_wide(2, s[0], 32'(a), 32'(b), tq, tr);
                end
            end
        end

        repeat (2) @(negedge clk);
        check("w8_queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
